// File: rtl/cpu_pkg.sv
// Shared core definitions: address width, reset vector, fetch step and
// the pre-IF PC generator state encoding.
package cpu_pkg;

    localparam int unsigned CPU_ADDR_W     = 32;
    localparam logic [31:0] CPU_RESET_PC   = 32'h1c000000;
    localparam int unsigned CPU_INST_BYTES = 4;

    typedef enum logic [1:0] {
        PC_RUN     = 2'd0,
        PC_PEND    = 2'd1,
        PC_PEND_EX = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer for the pre-IF PC generator.
// Only instantiated when PC_GEN_BTB_EN is defined.
module pc_btb #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned ENTRIES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lookup_valid_i,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    output logic              hit_o,
    output logic [ADDR_W-1:0] target_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_pc_i,
    input  logic [ADDR_W-1:0] wr_target_i,
    input  logic              mispredict_i
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q [ENTRIES];
    logic [IDX_W-1:0]   lk_idx, wr_idx, last_idx_q;
    logic [TAG_W-1:0]   lk_tag, wr_tag;
    logic               last_hit_q;
    logic               unused_lsbs;

    assign lk_idx      = lookup_pc_i[IDX_W+1:2];
    assign lk_tag      = lookup_pc_i[ADDR_W-1:IDX_W+2];
    assign wr_idx      = wr_pc_i[IDX_W+1:2];
    assign wr_tag      = wr_pc_i[ADDR_W-1:IDX_W+2];
    assign unused_lsbs = ^{lookup_pc_i[1:0], wr_pc_i[1:0]};

    assign hit_o    = lookup_valid_i & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
    assign target_o = tgt_q[lk_idx];

    // A redirect right after a predicted fetch means that prediction was wrong;
    // a same-cycle training write to the same slot takes precedence.
    always_comb begin
        valid_d = valid_q;
        if (mispredict_i && last_hit_q) valid_d[last_idx_q] = 1'b0;
        if (wr_en_i) valid_d[wr_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            last_hit_q <= 1'b0;
            last_idx_q <= '0;
        end else begin
            valid_q    <= valid_d;
            last_hit_q <= hit_o;
            last_idx_q <= lk_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx] <= wr_tag;
            tgt_q[wr_idx] <= wr_target_i;
        end
    end

endmodule

// File: rtl/pre_if_pc_gen.sv
// Pre-IF fetch PC generator: SRAM req/addr_ok handshake, EX/WB redirects,
// pending-redirect buffering. Optional BTB enabled by macro PC_GEN_BTB_EN.
module pre_if_pc_gen
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W      = CPU_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC    = CPU_RESET_PC,
    parameter int unsigned       INST_BYTES  = CPU_INST_BYTES,
    parameter int unsigned       BTB_ENTRIES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_allow_in,
    input  logic              inst_addr_ok,
    input  logic              wb_ex_valid,
    input  logic [ADDR_W-1:0] wb_ex_target,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] br_pc,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    output logic              pre_if_to_if_valid,
    output logic [ADDR_W-1:0] pre_if_pc,
    output logic              pre_if_cancel
);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    logic              outs_q, outs_d;
    logic [ADDR_W-1:0] sel_addr, seq_pc, next_pc;
    logic              req, fire, pend_valid, pend_prio, br_eff, redirect;

    assign req        = ~rst & if_allow_in;
    assign fire       = req & inst_addr_ok;
    assign pend_valid = (state_q != PC_RUN);
    assign pend_prio  = (state_q == PC_PEND_EX);
    // A held exception locks out branches from both selection and latching.
    assign br_eff     = br_taken & ~pend_prio;
    assign redirect   = wb_ex_valid | br_eff;

    always_comb begin
        if (wb_ex_valid)     sel_addr = wb_ex_target;
        else if (br_eff)     sel_addr = br_target;
        else if (pend_valid) sel_addr = pend_target_q;
        else                 sel_addr = pc_q;
    end

    assign seq_pc = sel_addr + ADDR_W'(INST_BYTES);

`ifdef PC_GEN_BTB_EN
    logic              btb_hit;
    logic [ADDR_W-1:0] btb_target;

    pc_btb #(
        .ADDR_W  (ADDR_W),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk            (clk),
        .rst            (rst),
        .lookup_valid_i (fire),
        .lookup_pc_i    (sel_addr),
        .hit_o          (btb_hit),
        .target_o       (btb_target),
        .wr_en_i        (br_taken),
        .wr_pc_i        (br_pc),
        .wr_target_i    (br_target),
        .mispredict_i   (redirect)
    );

    assign next_pc = btb_hit ? btb_target : seq_pc;
`else
    logic unused_br_pc;
    assign unused_br_pc = ^br_pc;
    assign next_pc      = seq_pc;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        outs_d        = outs_q;
        if (fire) begin
            state_d = PC_RUN;
            pc_d    = next_pc;
        end else if (wb_ex_valid) begin
            state_d       = PC_PEND_EX;
            pend_target_d = wb_ex_target;
        end else if (br_eff) begin
            state_d       = PC_PEND;
            pend_target_d = br_target;
        end
        if (fire)             outs_d = 1'b1;
        else if (if_allow_in) outs_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= PC_RUN;
            pc_q          <= RESET_PC;
            pend_target_q <= '0;
            outs_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            outs_q        <= outs_d;
        end
    end

    assign inst_req           = req;
    assign inst_addr          = sel_addr;
    assign pre_if_to_if_valid = fire;
    assign pre_if_pc          = sel_addr;
    assign pre_if_cancel      = ~rst & redirect & outs_q;

endmodule

// File: tb/tb_pre_if_pc_gen.sv
// Directed bench for pre_if_pc_gen with a scoreboard of PCs handed to IF.
module tb_pre_if_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_allow_in, inst_addr_ok;
    logic        wb_ex_valid, br_taken;
    logic [31:0] wb_ex_target, br_target, br_pc;
    logic        inst_req, pre_if_to_if_valid, pre_if_cancel;
    logic [31:0] inst_addr, pre_if_pc;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] sb[$];

    localparam logic [31:0] NOPC = 32'h1c0ff0f0;

    always #5 clk = ~clk;

    pre_if_pc_gen dut (
        .clk                (clk),
        .rst                (rst),
        .if_allow_in        (if_allow_in),
        .inst_addr_ok       (inst_addr_ok),
        .wb_ex_valid        (wb_ex_valid),
        .wb_ex_target       (wb_ex_target),
        .br_taken           (br_taken),
        .br_target          (br_target),
        .br_pc              (br_pc),
        .inst_req           (inst_req),
        .inst_addr          (inst_addr),
        .pre_if_to_if_valid (pre_if_to_if_valid),
        .pre_if_pc          (pre_if_pc),
        .pre_if_cancel      (pre_if_cancel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, then check outputs at the falling edge.
    task automatic step(input string tag, input logic allow, input logic ok,
                        input logic ex, input logic [31:0] ext,
                        input logic br, input logic [31:0] brt, input logic [31:0] brpc,
                        input logic [31:0] exp_addr, input logic exp_fire,
                        input logic exp_cancel);
        if_allow_in  = allow;
        inst_addr_ok = ok;
        wb_ex_valid  = ex;
        wb_ex_target = ext;
        br_taken     = br;
        br_target    = brt;
        br_pc        = brpc;
        if (exp_fire) sb.push_back(exp_addr);
        @(negedge clk);
        chk({tag, ".req"},    {31'd0, inst_req}, {31'd0, allow});
        chk({tag, ".addr"},   inst_addr, exp_addr);
        chk({tag, ".valid"},  {31'd0, pre_if_to_if_valid}, {31'd0, exp_fire});
        chk({tag, ".cancel"}, {31'd0, pre_if_cancel}, {31'd0, exp_cancel});
        if (pre_if_to_if_valid) begin
            n_tests++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL %s.sb: observed pc %h expected no handoff", tag, pre_if_pc);
            end
            if (sb.size() != 0) chk({tag, ".if_pc"}, pre_if_pc, sb.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_check(input string tag);
        @(negedge clk);
        chk({tag, ".req"},    {31'd0, inst_req}, 32'd0);
        chk({tag, ".valid"},  {31'd0, pre_if_to_if_valid}, 32'd0);
        chk({tag, ".cancel"}, {31'd0, pre_if_cancel}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_allow_in = 1'b1; inst_addr_ok = 1'b1;
        wb_ex_valid = 1'b0; wb_ex_target = '0;
        br_taken = 1'b0; br_target = '0; br_pc = '0;
        @(posedge clk);
        #1;
        reset_check("rst0");
        rst = 1'b0;

        // sequential fetch from the reset vector
        step("seq0", 1, 1, 0, 0, 0, 0, NOPC, 32'h1c000000, 1, 0);
        step("seq1", 1, 1, 0, 0, 0, 0, NOPC, 32'h1c000004, 1, 0);
        step("seq2", 1, 1, 0, 0, 0, 0, NOPC, 32'h1c000008, 1, 0);

        // branch while SRAM stalls three cycles
        step("br0", 1, 0, 0, 0, 1, 32'h1c000100, NOPC, 32'h1c000100, 0, 1);
        step("br1", 1, 0, 0, 0, 0, 0, NOPC, 32'h1c000100, 0, 0);
        step("br2", 1, 0, 0, 0, 0, 0, NOPC, 32'h1c000100, 0, 0);
        step("br3", 1, 1, 0, 0, 0, 0, NOPC, 32'h1c000100, 1, 0);
        step("br4", 1, 1, 0, 0, 0, 0, NOPC, 32'h1c000104, 1, 0);

        // exception overrides pending branch, later branches locked out
        step("ex0", 1, 0, 0, 0, 1, 32'h1c000100, NOPC, 32'h1c000100, 0, 1);
        step("ex1", 1, 0, 1, 32'h1c008000, 0, 0, NOPC, 32'h1c008000, 0, 0);
        step("ex2", 1, 0, 0, 0, 1, 32'h1c000200, NOPC, 32'h1c008000, 0, 0);
        step("ex3", 1, 1, 0, 0, 1, 32'h1c000300, NOPC, 32'h1c008000, 1, 0);
        step("ex4", 1, 1, 0, 0, 0, 0, NOPC, 32'h1c008004, 1, 0);

        // simultaneous exception and branch with a request outstanding
        step("sim0", 1, 1, 1, 32'h1c008000, 1, 32'h1c000200, NOPC, 32'h1c008000, 1, 1);
        step("sim1", 1, 1, 0, 0, 0, 0, NOPC, 32'h1c008004, 1, 0);

        // address wrap-around
        step("wrap0", 1, 1, 0, 0, 1, 32'hfffffffc, NOPC, 32'hfffffffc, 1, 1);
        step("wrap1", 1, 1, 0, 0, 0, 0, NOPC, 32'h00000000, 1, 0);
        step("wrap2", 1, 1, 0, 0, 0, 0, NOPC, 32'h00000004, 1, 0);

        // IF not accepting: no request
        step("hold0", 0, 1, 0, 0, 0, 0, NOPC, 32'h00000008, 0, 0);

        // reset while an exception is pending
        step("rpx0", 1, 0, 1, 32'h1c008000, 0, 0, NOPC, 32'h1c008000, 0, 1);
        rst = 1'b1; wb_ex_valid = 1'b0; inst_addr_ok = 1'b1;
        reset_check("rst1");
        rst = 1'b0;
        step("rpx1", 1, 1, 0, 0, 0, 0, NOPC, 32'h1c000000, 1, 0);
        step("rpx2", 1, 1, 0, 0, 0, 0, NOPC, 32'h1c000004, 1, 0);

`ifdef PC_GEN_BTB_EN
        // train 1c000010 -> 1c000400, then fetch 1c000010 and follow prediction
        step("btb0", 1, 1, 0, 0, 1, 32'h1c000400, 32'h1c000010, 32'h1c000400, 1, 1);
        step("btb1", 1, 1, 0, 0, 1, 32'h1c000010, 32'h1c000020, 32'h1c000010, 1, 1);
        step("btb2", 1, 1, 0, 0, 0, 0, NOPC, 32'h1c000400, 1, 0);
        step("btb3", 1, 1, 0, 0, 0, 0, NOPC, 32'h1c000404, 1, 0);
`endif

        n_tests++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
